// File: rtl/calc_pkg.sv
// calc_pkg: keypad key codes, key map and scanner FSM states shared with the calculator
`timescale 1ns/1ps
package calc_pkg;
  localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4, KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8, KEY_9 = 4'd9, KEY_A = 4'b1010, KEY_B = 4'b1011;
  localparam logic [3:0] KEY_C = 4'b1100, KEY_D = 4'b1101, KEY_E = 4'b1110, KEY_F = 4'b1111;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;
  // column index of the single low bit in a one-cold column pattern
  function automatic logic [1:0] col_of(input logic [3:0] pat);
    return !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: return KEY_1;
      4'h1: return KEY_2;
      4'h2: return KEY_3;
      4'h3: return KEY_A;
      4'h4: return KEY_4;
      4'h5: return KEY_5;
      4'h6: return KEY_6;
      4'h7: return KEY_B;
      4'h8: return KEY_7;
      4'h9: return KEY_8;
      4'hA: return KEY_9;
      4'hB: return KEY_C;
      4'hC: return KEY_E;
      4'hD: return KEY_0;
      4'hE: return KEY_F;
      default: return KEY_D;
    endcase
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser, resets to all ones to match idle pulled-up inputs
`timescale 1ns/1ps
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, m} <= '1;
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce and key-to-command translation
`timescale 1ns/1ps
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic [3:0] cmd,
  output logic       cmd_strobe,
  output logic       key_down
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  kp_state_t     state;
  logic [3:0]    cs, pat;
  logic [1:0]    row;
  logic [SW-1:0] sc;
  logic [DW-1:0] dc, dn;
  logic          dwell_end, all_up, one_low, dc_done;
  sync_2ff #(.W(4)) u_sync (.clock(clock), .reset(reset), .d(cols_n), .q(cs));
  assign dn        = dc + 1'b1;
  assign dc_done   = dn == DW'(DEBOUNCE_CNT);
  assign dwell_end = sc == SW'(SCAN_DIV - 1);
  assign all_up    = &cs;
  assign one_low   = $onehot(~cs);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= SCAN;
      rows_n     <= 4'b1110;
      row        <= 2'd0;
      sc         <= '0;
      dc         <= '0;
      pat        <= '1;
      cmd        <= 4'd0;
      cmd_strobe <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      case (state)
        SCAN:
          if (dwell_end) begin
            sc <= '0;
            if (one_low) begin
              state <= DEBOUNCE;
              pat   <= cs;
              dc    <= '0;
            end else begin
              row    <= row + 2'd1;
              rows_n <= {rows_n[2:0], rows_n[3]};
            end
          end else sc <= sc + 1'b1;
        DEBOUNCE:
          if (cs != pat) begin
            state  <= SCAN;
            row    <= row + 2'd1;
            rows_n <= {rows_n[2:0], rows_n[3]};
          end else begin
            dc <= dn;
            if (dc_done) begin
              state      <= HELD;
              cmd        <= key_code(row, col_of(pat));
              cmd_strobe <= 1'b1;
              key_down   <= 1'b1;
            end
          end
        HELD:
          if (all_up) begin
            state <= RELEASE;
            dc    <= '0;
          end
        RELEASE:
          if (!all_up) state <= HELD;
          else begin
            dc <= dn;
            if (dc_done) begin
              state    <= SCAN;
              key_down <= 1'b0;
              row      <= row + 2'd1;
              rows_n   <= {rows_n[2:0], rows_n[3]};
            end
          end
      endcase
    end
endmodule
